bfloat16_accum: RTL and testbench

//  Streaming bfloat16 accumulator directly downstream of the bfloat16 multiplier.
//  - Sums a frame of bfloat16 products (terminated by in_last) into one bfloat16 result.
//  - Multi-cycle align/add/normalise FSM; valid/ready handshake on both sides.
//  - Numeric conventions match the multiplier: flush-to-zero, canonical NaN 0x7F81.

---
 rtl/bfloat16_accum.sv | 213 +++++++++++++++++++++
 tb/tb_bfloat16_accum.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bfloat16_accum.sv
// bfloat16_accum: streaming bfloat16 frame accumulator, 4-cycle align/add/norm FSM.
// Define BF16_ACC_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module bfloat16_accum #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_data,
  output logic [COUNT_W-1:0] out_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]        r_term;
  logic               r_last;
  logic [15:0]        r_acc;
  logic               r_nan;
  logic               r_skip;
  logic [COUNT_W-1:0] r_count;
  logic [10:0]        r_big;
  logic [10:0]        r_sml;
  logic [7:0]         r_exp;
  logic               r_sign;
  logic               r_sub;
  logic [11:0]        r_sum;

  logic [10:0] w_a_m;
  logic [10:0] w_b_m;
  logic        w_a_ge;
  logic [10:0] w_big_m;
  logic [10:0] w_sml_m;
  logic [7:0]  w_big_e;
  logic [7:0]  w_sml_e;
  logic        w_big_s;
  logic [7:0]  w_diff;
  logic [10:0] w_mask;
  logic [10:0] w_sml;
  logic        w_b_nan;
  logic        w_b_inf;
  logic        w_a_inf;

  logic [3:0]        w_lz;
  logic [10:0]       w_norm;
  logic signed [9:0] w_e;
  logic signed [9:0] w_e2;
  logic              w_rnd;
  logic [8:0]        w_m9;
  logic [6:0]        w_man;
  logic [15:0]       w_res;

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_ALIGN;
      end
      S_ALIGN: w_next = S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM:  w_next = r_last ? S_DONE : S_IDLE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign out_data  = r_nan ? 16'h7F81 : r_acc;
  assign out_count = r_count;

  assign w_b_nan = (r_term[14:7] == 8'hFF) && (r_term[6:0] != 7'd0);
  assign w_b_inf = (r_term[14:7] == 8'hFF) && (r_term[6:0] == 7'd0);
  assign w_a_inf = (r_acc[14:7] == 8'hFF);

  // Zero/denormal operands carry a zero mantissa so they never win the compare.
  always_comb begin
    w_a_m  = (r_acc[14:7] != 8'd0) ? {1'b1, r_acc[6:0], 3'b000} : 11'd0;
    w_b_m  = (r_term[14:7] != 8'd0) ? {1'b1, r_term[6:0], 3'b000} : 11'd0;
    w_a_ge = {r_acc[14:7], w_a_m} >= {r_term[14:7], w_b_m};
    if (w_a_ge) begin
      w_big_m = w_a_m;
      w_big_e = r_acc[14:7];
      w_big_s = r_acc[15];
      w_sml_m = w_b_m;
      w_sml_e = r_term[14:7];
    end else begin
      w_big_m = w_b_m;
      w_big_e = r_term[14:7];
      w_big_s = r_term[15];
      w_sml_m = w_a_m;
      w_sml_e = r_acc[14:7];
    end
    w_diff = w_big_e - w_sml_e;
    w_mask = (11'd1 << w_diff) - 11'd1;
    if (w_diff >= 8'd11) begin
      w_sml = {10'd0, |w_sml_m};
    end else begin
      w_sml = (w_sml_m >> w_diff) | {10'd0, |(w_sml_m & w_mask)};
    end
  end

  always_comb begin
    w_lz = 4'd0;
    for (int i = 0; i < 11; i++) begin
      if (r_sum[i]) w_lz = 4'(10 - i);
    end
    if (r_sum[11]) begin
      w_norm = {r_sum[11:2], r_sum[1] | r_sum[0]};
      w_e    = $signed({2'b00, r_exp}) + 10'sd1;
    end else begin
      w_norm = r_sum[10:0] << w_lz;
      w_e    = $signed({2'b00, r_exp}) - $signed({6'd0, w_lz});
    end
`ifdef BF16_ACC_RNE_EN
    w_rnd = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
`else
    w_rnd = 1'b0;
`endif
    w_m9  = {1'b0, w_norm[10:3]} + {8'd0, w_rnd};
    w_man = w_m9[8] ? w_m9[7:1] : w_m9[6:0];
    w_e2  = w_m9[8] ? w_e + 10'sd1 : w_e;
    if (r_sum == 12'd0) begin
      w_res = 16'h0000;
    end else if (w_e2 >= 10'sd255) begin
      w_res = {r_sign, 8'hFF, 7'h00};
    end else if (w_e2 <= 10'sd0) begin
      w_res = {r_sign, 15'h0000};
    end else begin
      w_res = {r_sign, w_e2[7:0], w_man};
    end
  end

`ifndef BF16_ACC_RNE_EN
  logic w_unused_grs;
  assign w_unused_grs = ^w_norm[2:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_term  <= 16'h0000;
      r_last  <= 1'b0;
      r_acc   <= 16'h0000;
      r_nan   <= 1'b0;
      r_skip  <= 1'b0;
      r_count <= '0;
      r_big   <= 11'd0;
      r_sml   <= 11'd0;
      r_exp   <= 8'd0;
      r_sign  <= 1'b0;
      r_sub   <= 1'b0;
      r_sum   <= 12'd0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_term <= in_data;
            r_last <= in_last;
            if (r_count != '1) r_count <= r_count + 1'b1;
          end
        end
        S_ALIGN: begin
          r_skip <= r_nan | w_b_nan | w_a_inf | w_b_inf;
          if (w_b_nan || (w_a_inf && w_b_inf && (r_acc[15] != r_term[15]))) begin
            r_nan <= 1'b1;
          end else if (w_b_inf && !r_nan) begin
            r_acc <= {r_term[15], 8'hFF, 7'h00};
          end
          r_big  <= w_big_m;
          r_sml  <= w_sml;
          r_exp  <= w_big_e;
          r_sign <= w_big_s;
          r_sub  <= r_acc[15] ^ r_term[15];
        end
        S_ADD: begin
          r_sum <= r_sub ? {1'b0, r_big} - {1'b0, r_sml}
                         : {1'b0, r_big} + {1'b0, r_sml};
        end
        S_NORM: begin
          if (!r_skip) r_acc <= w_res;
        end
        S_DONE: begin
          if (out_ready) begin
            r_acc   <= 16'h0000;
            r_count <= '0;
            r_nan   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bfloat16_accum.sv
// tb_bfloat16_accum: directed frames checked against a real-arithmetic bfloat16 model
// and hand-computed literals.
module tb_bfloat16_accum;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic [15:0]   in_data = 16'h0000;
  logic          in_ready;
  logic          out_valid;
  logic [15:0]   out_data;
  logic [CW-1:0] out_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] frame[$];
  logic [15:0] q_d[$];
  int          q_c[$];

  bfloat16_accum #(.COUNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic real pw2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r * 0.5;
    return r;
  endfunction

  function automatic real b2r(input logic [15:0] b);
    real v;
    if (b[14:7] == 8'd0) return 0.0;
    v = (1.0 + real'(int'(b[6:0])) / 128.0) * pw2(int'(b[14:7]) - 127);
    return b[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2b(input real v);
    logic s;
    real  a, m, rem;
    int   e, mi, be;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= pw2(e + 1)) e++;
    while (a < pw2(e)) e--;
    m = a / pw2(e) * 128.0;
    mi = $rtoi(m);
    rem = m - real'(mi);
`ifdef BF16_ACC_RNE_EN
    if (rem > 0.5 || (rem == 0.5 && (mi % 2) == 1)) mi++;
`endif
    if (mi == 256) begin
      mi = 128;
      e++;
    end
    be = e + 127;
    if (be >= 255) return {s, 8'hFF, 7'h00};
    if (be <= 0) return {s, 15'h0000};
    return {s, be[7:0], mi[6:0]};
  endfunction

  function automatic logic [15:0] model_frame();
    logic [15:0] acc = 16'h0000;
    logic        nan = 1'b0;
    foreach (frame[i]) begin
      logic [15:0] t = frame[i];
      if (!nan) begin
        if (t[14:7] == 8'hFF && t[6:0] != 7'd0) nan = 1'b1;
        else if (t[14:7] == 8'hFF) begin
          if (acc[14:7] == 8'hFF && acc[15] != t[15]) nan = 1'b1;
          else acc = t;
        end else if (acc[14:7] != 8'hFF) begin
          acc = r2b(b2r(acc) + b2r(t));
        end
      end
    end
    return nan ? 16'h7F81 : acc;
  endfunction

  // Model comparison on every cycle an output is presented.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q_d.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %h with no frame pending", out_data);
      end else begin
        chk("model_data", out_data, q_d[0]);
        chk("model_count", 16'(out_count), 16'(q_c[0]));
        chk("model_in_ready", 16'(in_ready), 16'd0);
        if (out_ready) begin
          void'(q_d.pop_front());
          void'(q_c.pop_front());
        end
      end
    end
  end

  task automatic accept(input logic [15:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_ready", 16'(in_ready), 16'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    frame.push_back(d);
    if (l) begin
      q_d.push_back(model_frame());
      q_c.push_back(frame.size() > 255 ? 255 : frame.size());
      frame.delete();
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    accept(d, l);
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) begin
        chk("ready_t4", 16'(in_ready), 16'(!l));
        chk("valid_t4", 16'(out_valid), 16'(l));
      end else begin
        chk("busy_ready", 16'(in_ready), 16'd0);
        chk("busy_valid", 16'(out_valid), 16'd0);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic take(input logic [15:0] d, input int c, input logic lit);
    chk("take_valid", 16'(out_valid), 16'd1);
    if (lit) begin
      chk("lit_data", out_data, d);
      chk("lit_count", 16'(out_count), 16'(c));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_ready", 16'(in_ready), 16'd1);
    chk("post_valid", 16'(out_valid), 16'd0);
    chk("post_count", 16'(out_count), 16'd0);
    chk("post_data", out_data, 16'h0000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", 16'(in_ready), 16'd1);
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_data", out_data, 16'h0000);
    chk("rst_count", 16'(out_count), 16'd0);

    send(16'h3F80, 1'b1); take(16'h3F80, 1, 1'b1);
    repeat (3) send(16'h3F80, 1'b0);
    send(16'h3F80, 1'b1); take(16'h4080, 4, 1'b1);
    send(16'h3F80, 1'b0); send(16'hBF80, 1'b1); take(16'h0000, 2, 1'b1);
    send(16'h0001, 1'b0); send(16'h3F80, 1'b1); take(16'h3F80, 2, 1'b1);
    send(16'h3F80, 1'b0); send(16'hBF7F, 1'b1); take(16'h3B80, 2, 1'b1);
    send(16'h7F80, 1'b0); send(16'hFF80, 1'b1); take(16'h7F81, 2, 1'b1);
    send(16'h7F7F, 1'b0); send(16'h7F7F, 1'b1); take(16'h7F80, 2, 1'b1);
    send(16'h7FC0, 1'b0); send(16'h3F80, 1'b1); take(16'h7F81, 2, 1'b1);
    send(16'h0080, 1'b0); send(16'h0080, 1'b1); take(16'h0100, 2, 1'b1);
    send(16'h8100, 1'b0); send(16'h00C0, 1'b1); take(16'h8000, 2, 1'b1);

    send(16'h3F80, 1'b0); send(16'h3F80, 1'b1);
    repeat (5) begin
      chk("stall_data", out_data, 16'h4000);
      chk("stall_count", 16'(out_count), 16'd2);
      chk("stall_ready", 16'(in_ready), 16'd0);
      @(posedge clk); #1;
    end
    take(16'h4000, 2, 1'b1);
    send(16'h4000, 1'b1); take(16'h4000, 1, 1'b1);

    send(16'h3F80, 1'b0); send(16'h3BC0, 1'b1);
`ifdef BF16_ACC_RNE_EN
    take(16'h3F81, 2, 1'b1);
`else
    take(16'h3F80, 2, 1'b1);
`endif

    send(16'h4049, 1'b0); send(16'hC000, 1'b0); send(16'h3E00, 1'b1);
    take(16'h0000, 0, 1'b0);
    send(16'hC2F7, 1'b0); send(16'h4120, 1'b0); send(16'h3DCD, 1'b0);
    send(16'hBF00, 1'b1); take(16'h0000, 0, 1'b0);

    send(16'h3F80, 1'b0);
    accept(16'h4000, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    frame.delete();
    chk("midrst_ready", 16'(in_ready), 16'd1);
    chk("midrst_count", 16'(out_count), 16'd0);
    chk("midrst_data", out_data, 16'h0000);
    chk("midrst_valid", 16'(out_valid), 16'd0);
    send(16'h4040, 1'b1); take(16'h4040, 1, 1'b1);

    repeat (259) send(16'h0000, 1'b0);
    send(16'h0000, 1'b1); take(16'h0000, 255, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 16'(q_d.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
